// File: rtl/niu_sio_pkg.sv
// Shared types and constants for the NIU DMA-response receive path.
// Optional parity checking is enabled by defining NIU_SIO_PAR_CHK_EN.
package niu_sio_pkg;

  localparam int HDR_W  = 128;
  localparam int BEAT_W = 128;
  localparam int BEATS  = 4;
  localparam int PAR_W  = 8;
  localparam int DATA_W = BEAT_W * BEATS;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic [HDR_W-1:0]  hdr;
    logic [DATA_W-1:0] data;
    logic              has_data;
    logic              par_err;
  } rsp_t;

  // Even parity per 16-bit lane: bit i is the XOR of beat[16i+15:16i].
  function automatic logic [PAR_W-1:0] beat_parity(input logic [BEAT_W-1:0] beat);
    logic [PAR_W-1:0] par;
    for (int i = 0; i < PAR_W; i++) begin
      par[i] = ^beat[16*i +: 16];
    end
    return par;
  endfunction

endpackage

// File: rtl/niu_sio_rsp_fifo.sv
// Show-ahead FIFO of completed responses. Head entry is presented whenever
// the FIFO is non-empty; output reads as zero while empty.
module niu_sio_rsp_fifo
  import niu_sio_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  rsp_t wdata_i,
  input  logic pop_i,
  output rsp_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rsp_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_s;
  logic             rd_s;

  assign empty_o = (cnt_q == {CNT_W{1'b0}});
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign rd_s    = pop_i & ~empty_o;
  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign wr_s    = push_i & (~full_o | rd_s);

  // Entry storage; written at the tail, no reset needed for payload.
  always_ff @(posedge clk_i) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      if (wr_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_s, rd_s})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    if (empty_o) begin
      rdata_o = '0;
    end else begin
      rdata_o = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/niu_sio_dmarsp_rx.sv
// Receives DMA responses from the SIU (header plus optional four payload
// beats), buffers completed responses and returns one credit per entry freed.
// Define NIU_SIO_PAR_CHK_EN to enable per-beat payload parity checking.
module niu_sio_dmarsp_rx
  import niu_sio_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              iol2clk,
  input  logic              rst,
  input  logic              sio_niu_hdr_vld,
  input  logic              sio_niu_datareq,
  input  logic [BEAT_W-1:0] sio_niu_data,
  input  logic [PAR_W-1:0]  sio_niu_parity,
  output logic              niu_sio_credit,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [HDR_W-1:0]  rsp_hdr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_has_data,
  output logic              rsp_par_err,
  output logic              proto_err,
  output logic              ovf_err
);

  rx_state_e             state_q, state_d;
  logic [1:0]            beat_cnt_q, beat_cnt_d;
  logic [HDR_W-1:0]      hdr_q, hdr_d;
  logic [3*BEAT_W-1:0]   data_q, data_d;
  logic                  par_acc_q, par_acc_d;
  logic                  beat_err_s;
  logic                  push_s;
  rsp_t                  push_rsp_s;
  logic                  proto_set_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  pop_s;
  logic                  drop_s;
  rsp_t                  head_s;
  logic                  credit_q;
  logic                  proto_err_q;
  logic                  ovf_err_q;

`ifdef NIU_SIO_PAR_CHK_EN
  assign beat_err_s = |(beat_parity(sio_niu_data) ^ sio_niu_parity);
`else
  logic unused_par_s;
  assign unused_par_s = ^sio_niu_parity;
  assign beat_err_s   = 1'b0;
`endif

  // Next-state: header capture, beat collection and response completion.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    hdr_d       = hdr_q;
    data_d      = data_q;
    par_acc_d   = par_acc_q;
    push_s      = 1'b0;
    push_rsp_s  = '0;
    proto_set_s = 1'b0;
    if (sio_niu_hdr_vld) begin
      // A header always restarts reception; any partial payload is discarded.
      proto_set_s = (state_q == ST_PAYLOAD);
      if (sio_niu_datareq) begin
        hdr_d      = sio_niu_data;
        beat_cnt_d = 2'd0;
        par_acc_d  = 1'b0;
        state_d    = ST_PAYLOAD;
      end else begin
        push_s              = 1'b1;
        push_rsp_s.hdr      = sio_niu_data;
        push_rsp_s.data     = '0;
        push_rsp_s.has_data = 1'b0;
        push_rsp_s.par_err  = 1'b0;
        state_d             = ST_IDLE;
      end
    end else if (state_q == ST_PAYLOAD) begin
      case (beat_cnt_q)
        2'd0: data_d[BEAT_W-1:0]          = sio_niu_data;
        2'd1: data_d[2*BEAT_W-1:BEAT_W]   = sio_niu_data;
        2'd2: data_d[3*BEAT_W-1:2*BEAT_W] = sio_niu_data;
        2'd3: begin
          push_s              = 1'b1;
          push_rsp_s.hdr      = hdr_q;
          push_rsp_s.data     = {sio_niu_data, data_q};
          push_rsp_s.has_data = 1'b1;
          push_rsp_s.par_err  = par_acc_q | beat_err_s;
          state_d             = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      beat_cnt_d = beat_cnt_q + 2'd1;
      par_acc_d  = par_acc_q | beat_err_s;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Receive-side state registers.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= 2'd0;
      hdr_q      <= '0;
      data_q     <= '0;
      par_acc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      hdr_q      <= hdr_d;
      data_q     <= data_d;
      par_acc_q  <= par_acc_d;
    end
  end

  assign pop_s  = rsp_rdy & ~fifo_empty_s;
  assign drop_s = push_s & fifo_full_s & ~pop_s;

  niu_sio_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (iol2clk),
    .rst_i   (rst),
    .push_i  (push_s),
    .wdata_i (push_rsp_s),
    .pop_i   (rsp_rdy),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Credit pulse one cycle after each dequeue, plus sticky error flags.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      credit_q    <= 1'b0;
      proto_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      credit_q    <= pop_s;
      proto_err_q <= proto_err_q | proto_set_s;
      ovf_err_q   <= ovf_err_q | drop_s;
    end
  end

  assign niu_sio_credit = credit_q;
  assign proto_err      = proto_err_q;
  assign ovf_err        = ovf_err_q;
  assign rsp_vld        = ~fifo_empty_s;
  assign rsp_hdr        = head_s.hdr;
  assign rsp_data       = head_s.data;
  assign rsp_has_data   = head_s.has_data;
  assign rsp_par_err    = head_s.par_err;

endmodule

// File: tb/tb_niu_sio_dmarsp_rx.sv
// Directed self-checking bench for niu_sio_dmarsp_rx (DEPTH=2).
module tb_niu_sio_dmarsp_rx;

  logic         iol2clk;
  logic         rst;
  logic         sio_niu_hdr_vld;
  logic         sio_niu_datareq;
  logic [127:0] sio_niu_data;
  logic [7:0]   sio_niu_parity;
  logic         niu_sio_credit;
  logic         rsp_vld;
  logic         rsp_rdy;
  logic [127:0] rsp_hdr;
  logic [511:0] rsp_data;
  logic         rsp_has_data;
  logic         rsp_par_err;
  logic         proto_err;
  logic         ovf_err;

  int total = 0;
  int bad   = 0;

`ifdef NIU_SIO_PAR_CHK_EN
  localparam logic EXP_PAR_ERR = 1'b1;
`else
  localparam logic EXP_PAR_ERR = 1'b0;
`endif

  niu_sio_dmarsp_rx #(.DEPTH(2)) dut (
    .iol2clk         (iol2clk),
    .rst             (rst),
    .sio_niu_hdr_vld (sio_niu_hdr_vld),
    .sio_niu_datareq (sio_niu_datareq),
    .sio_niu_data    (sio_niu_data),
    .sio_niu_parity  (sio_niu_parity),
    .niu_sio_credit  (niu_sio_credit),
    .rsp_vld         (rsp_vld),
    .rsp_rdy         (rsp_rdy),
    .rsp_hdr         (rsp_hdr),
    .rsp_data        (rsp_data),
    .rsp_has_data    (rsp_has_data),
    .rsp_par_err     (rsp_par_err),
    .proto_err       (proto_err),
    .ovf_err         (ovf_err)
  );

  initial iol2clk = 1'b0;
  always #5 iol2clk = ~iol2clk;

  task automatic step();
    @(posedge iol2clk);
    #1;
  endtask

  task automatic drive_hdr(input logic [127:0] h, input logic dr);
    sio_niu_hdr_vld = 1'b1;
    sio_niu_datareq = dr;
    sio_niu_data    = h;
    sio_niu_parity  = 8'h00;
    step();
  endtask

  task automatic drive_beat(input logic [127:0] d, input logic [7:0] p);
    sio_niu_hdr_vld = 1'b0;
    sio_niu_datareq = 1'b0;
    sio_niu_data    = d;
    sio_niu_parity  = p;
    step();
  endtask

  task automatic idle_in();
    sio_niu_hdr_vld = 1'b0;
    sio_niu_datareq = 1'b0;
    sio_niu_data    = 128'h0;
    sio_niu_parity  = 8'h00;
  endtask

  task automatic do_reset();
    idle_in();
    rsp_rdy = 1'b0;
    rst     = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b exp=0", rsp_vld); end
    total++; if (niu_sio_credit !== 1'b0) begin bad++; $display("FAIL reset_credit got=%0b exp=0", niu_sio_credit); end
    total++; if (proto_err !== 1'b0 || ovf_err !== 1'b0) begin bad++; $display("FAIL reset_errs got=%0b%0b exp=00", proto_err, ovf_err); end
    total++; if (rsp_hdr !== 128'h0 || rsp_data !== 512'h0) begin bad++; $display("FAIL reset_hdr_data got=%h exp=0", rsp_hdr); end
    total++; if (rsp_has_data !== 1'b0 || rsp_par_err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%0b%0b exp=00", rsp_has_data, rsp_par_err); end
  endtask

  // Header 0xA5 with four beats 1..4 (parities 01,01,00,01); consumer stalls first.
  task automatic test_payload();
    do_reset();
    drive_hdr(128'hA5, 1'b1);
    drive_beat(128'h1, 8'h01);
    drive_beat(128'h2, 8'h01);
    drive_beat(128'h3, 8'h00);
    total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL payload_early_vld got=%0b exp=0", rsp_vld); end
    drive_beat(128'h4, 8'h01);
    idle_in();
    total++; if (rsp_vld !== 1'b1) begin bad++; $display("FAIL payload_vld got=%0b exp=1", rsp_vld); end
    total++; if (rsp_data[511:384] !== 128'h4) begin bad++; $display("FAIL payload_beat3 got=%h exp=4", rsp_data[511:384]); end
    total++; if (rsp_data !== {128'h4, 128'h3, 128'h2, 128'h1}) begin bad++; $display("FAIL payload_data got=%h", rsp_data); end
    total++; if (rsp_hdr !== 128'hA5) begin bad++; $display("FAIL payload_hdr got=%h exp=a5", rsp_hdr); end
    total++; if (rsp_has_data !== 1'b1 || rsp_par_err !== 1'b0) begin bad++; $display("FAIL payload_flags got=%0b%0b exp=10", rsp_has_data, rsp_par_err); end
    step();
    total++; if (rsp_vld !== 1'b1 || rsp_hdr !== 128'hA5 || niu_sio_credit !== 1'b0) begin bad++; $display("FAIL payload_stall got vld=%0b hdr=%h cr=%0b exp 1/a5/0", rsp_vld, rsp_hdr, niu_sio_credit); end
    rsp_rdy = 1'b1;
    step();
    total++; if (rsp_vld !== 1'b0 || niu_sio_credit !== 1'b1) begin bad++; $display("FAIL payload_deq got vld=%0b cr=%0b exp 0/1", rsp_vld, niu_sio_credit); end
    step();
    total++; if (niu_sio_credit !== 1'b0) begin bad++; $display("FAIL payload_credit_end got=%0b exp=0", niu_sio_credit); end
  endtask

  task automatic test_hdr_only();
    do_reset();
    rsp_rdy = 1'b1;
    drive_hdr(128'h1234, 1'b0);
    idle_in();
    total++; if (rsp_vld !== 1'b1 || rsp_hdr !== 128'h1234) begin bad++; $display("FAIL hdronly_vld got vld=%0b hdr=%h exp 1/1234", rsp_vld, rsp_hdr); end
    total++; if (rsp_has_data !== 1'b0 || rsp_data !== 512'h0 || niu_sio_credit !== 1'b0) begin bad++; $display("FAIL hdronly_flags got hd=%0b cr=%0b exp 0/0", rsp_has_data, niu_sio_credit); end
    step();
    total++; if (rsp_vld !== 1'b0 || niu_sio_credit !== 1'b1) begin bad++; $display("FAIL hdronly_credit got vld=%0b cr=%0b exp 0/1", rsp_vld, niu_sio_credit); end
    step();
    total++; if (niu_sio_credit !== 1'b0) begin bad++; $display("FAIL hdronly_credit_end got=%0b exp=0", niu_sio_credit); end
  endtask

  // Beat 2 (value 3, true parity 00) sent with parity bit 0 flipped.
  task automatic test_parity();
    do_reset();
    drive_hdr(128'h5A, 1'b1);
    drive_beat(128'h1, 8'h01);
    drive_beat(128'h2, 8'h01);
    drive_beat(128'h3, 8'h01);
    drive_beat(128'h4, 8'h01);
    idle_in();
    total++; if (rsp_vld !== 1'b1 || rsp_par_err !== EXP_PAR_ERR) begin bad++; $display("FAIL parity_err got vld=%0b pe=%0b exp 1/%0b", rsp_vld, rsp_par_err, EXP_PAR_ERR); end
  endtask

  task automatic test_overflow();
    do_reset();
    drive_hdr(128'h11, 1'b0);
    total++; if (niu_sio_credit !== 1'b0) begin bad++; $display("FAIL ovf_credit1 got=%0b exp=0", niu_sio_credit); end
    drive_hdr(128'h22, 1'b0);
    total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b exp=0", ovf_err); end
    drive_hdr(128'h33, 1'b0);
    idle_in();
    total++; if (ovf_err !== 1'b1 || niu_sio_credit !== 1'b0) begin bad++; $display("FAIL ovf_set got ovf=%0b cr=%0b exp 1/0", ovf_err, niu_sio_credit); end
    total++; if (rsp_hdr !== 128'h11) begin bad++; $display("FAIL ovf_head got=%h exp=11", rsp_hdr); end
    rsp_rdy = 1'b1;
    step();
    total++; if (rsp_vld !== 1'b1 || rsp_hdr !== 128'h22 || niu_sio_credit !== 1'b1) begin bad++; $display("FAIL ovf_drain1 got vld=%0b hdr=%h cr=%0b exp 1/22/1", rsp_vld, rsp_hdr, niu_sio_credit); end
    step();
    total++; if (rsp_vld !== 1'b0 || niu_sio_credit !== 1'b1) begin bad++; $display("FAIL ovf_drain2 got vld=%0b cr=%0b exp 0/1", rsp_vld, niu_sio_credit); end
    step();
    total++; if (niu_sio_credit !== 1'b0 || ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got cr=%0b ovf=%0b exp 0/1", niu_sio_credit, ovf_err); end
  endtask

  // Full FIFO accepts a completion when the head is dequeued the same cycle.
  task automatic test_full_dequeue();
    do_reset();
    drive_hdr(128'h41, 1'b0);
    drive_hdr(128'h42, 1'b0);
    rsp_rdy = 1'b1;
    drive_hdr(128'h43, 1'b0);
    idle_in();
    total++; if (ovf_err !== 1'b0 || rsp_hdr !== 128'h42) begin bad++; $display("FAIL fulldeq_accept got ovf=%0b hdr=%h exp 0/42", ovf_err, rsp_hdr); end
    step();
    total++; if (rsp_vld !== 1'b1 || rsp_hdr !== 128'h43) begin bad++; $display("FAIL fulldeq_third got vld=%0b hdr=%h exp 1/43", rsp_vld, rsp_hdr); end
    step();
    total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL fulldeq_empty got=%0b exp=0", rsp_vld); end
  endtask

  // Second header at beat 1 aborts the first response (beat parities 00,00,01,01).
  task automatic test_proto();
    do_reset();
    drive_hdr(128'hB1, 1'b1);
    drive_beat(128'h10, 8'h01);
    drive_hdr(128'hB2, 1'b1);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_set got=%0b exp=1", proto_err); end
    drive_beat(128'h5, 8'h00);
    drive_beat(128'h6, 8'h00);
    drive_beat(128'h7, 8'h01);
    drive_beat(128'h8, 8'h01);
    idle_in();
    total++; if (rsp_vld !== 1'b1 || rsp_hdr !== 128'hB2) begin bad++; $display("FAIL proto_second got vld=%0b hdr=%h exp 1/b2", rsp_vld, rsp_hdr); end
    total++; if (rsp_data !== {128'h8, 128'h7, 128'h6, 128'h5} || rsp_par_err !== 1'b0) begin bad++; $display("FAIL proto_data got pe=%0b data=%h", rsp_par_err, rsp_data); end
    rsp_rdy = 1'b1;
    step();
    total++; if (rsp_vld !== 1'b0 || proto_err !== 1'b1) begin bad++; $display("FAIL proto_only_one got vld=%0b pe=%0b exp 0/1", rsp_vld, proto_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_hdr(128'hC1, 1'b1);
    drive_beat(128'h1, 8'h01);
    drive_beat(128'h2, 8'h01);
    rst = 1'b1;
    drive_beat(128'h3, 8'h00);
    drive_hdr(128'hEE, 1'b0);
    rst = 1'b0;
    idle_in();
    step();
    total++; if (rsp_vld !== 1'b0 || niu_sio_credit !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got vld=%0b cr=%0b exp 0/0", rsp_vld, niu_sio_credit); end
    drive_beat(128'h4, 8'h01);
    total++; if (rsp_vld !== 1'b0) begin bad++; $display("FAIL rstmid_stale got=%0b exp=0", rsp_vld); end
    drive_hdr(128'hC2, 1'b1);
    drive_beat(128'h1, 8'h01);
    drive_beat(128'h2, 8'h01);
    drive_beat(128'h3, 8'h00);
    drive_beat(128'h4, 8'h01);
    idle_in();
    total++; if (rsp_vld !== 1'b1 || rsp_hdr !== 128'hC2 || rsp_data !== {128'h4, 128'h3, 128'h2, 128'h1}) begin bad++; $display("FAIL rstmid_next got vld=%0b hdr=%h", rsp_vld, rsp_hdr); end
  endtask

  // Header-only response arrives the cycle right after beat 3.
  task automatic test_back_to_back();
    do_reset();
    rsp_rdy = 1'b1;
    drive_hdr(128'hD1, 1'b1);
    drive_beat(128'h1, 8'h01);
    drive_beat(128'h2, 8'h01);
    drive_beat(128'h3, 8'h00);
    drive_beat(128'h4, 8'h01);
    total++; if (rsp_vld !== 1'b1 || rsp_hdr !== 128'hD1 || rsp_has_data !== 1'b1) begin bad++; $display("FAIL b2b_first got vld=%0b hdr=%h hd=%0b", rsp_vld, rsp_hdr, rsp_has_data); end
    drive_hdr(128'hD2, 1'b0);
    idle_in();
    total++; if (rsp_vld !== 1'b1 || rsp_hdr !== 128'hD2 || rsp_has_data !== 1'b0 || niu_sio_credit !== 1'b1) begin bad++; $display("FAIL b2b_second got vld=%0b hdr=%h cr=%0b", rsp_vld, rsp_hdr, niu_sio_credit); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL b2b_proto got=%0b exp=0", proto_err); end
    step();
    total++; if (rsp_vld !== 1'b0 || niu_sio_credit !== 1'b1) begin bad++; $display("FAIL b2b_credit2 got vld=%0b cr=%0b exp 0/1", rsp_vld, niu_sio_credit); end
    step();
    total++; if (niu_sio_credit !== 1'b0) begin bad++; $display("FAIL b2b_credit_end got=%0b exp=0", niu_sio_credit); end
  endtask

  initial begin
    rst     = 1'b1;
    rsp_rdy = 1'b0;
    idle_in();
    test_reset();
    test_payload();
    test_hdr_only();
    test_parity();
    test_overflow();
    test_full_dequeue();
    test_proto();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/niu_sio_dmarsp_rx.md
NIU_SIO_DMARSP_RX -- requirements
Module: niu_sio_dmarsp_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of completed responses buffered (power of two, 2..8).
REQ-002 SHALL have port iol2clk  input  1  IO/L2 clock; sole clock, all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port sio_niu_hdr_vld  input  1  header cycle marker from SIU.
REQ-005 SHALL have port sio_niu_datareq  input  1  sampled with hdr_vld; 1 = four payload beats follow.
REQ-006 SHALL have port sio_niu_data  input  128  header in header cycle, payload in beat cycles.
REQ-007 SHALL have port sio_niu_parity  input  8  parity for sio_niu_data, payload beats only.
REQ-008 SHALL have port niu_sio_credit  output  1  one-cycle pulse per buffer entry freed.
REQ-009 SHALL have port rsp_vld  output  1  head response valid.
REQ-010 SHALL have port rsp_rdy  input  1  consumer accepts head when rsp_vld & rsp_rdy.
REQ-011 SHALL have port rsp_hdr  output  128  head response header.
REQ-012 SHALL have port rsp_data  output  512  head payload, beat0 in [127:0], beat3 in [511:384]; zero if no data.
REQ-013 SHALL have port rsp_has_data  output  1  head response carried payload.
REQ-014 SHALL have port rsp_par_err  output  1  head response had >=1 payload parity mismatch.
REQ-015 SHALL have port proto_err  output  1  sticky: header during payload collection.
REQ-016 SHALL have port ovf_err  output  1  sticky: completed response dropped, buffer full.

Function
REQ-017 SHALL implement FSM IDLE, PAYLOAD; 2-bit beat counter beat_cnt.
REQ-018 IDLE & hdr_vld & datareq: SHALL capture header, clear beat_cnt and parity accumulator, go PAYLOAD.
REQ-019 IDLE & hdr_vld & !datareq: SHALL complete a header-only response (has_data=0, data=0, par_err=0) that cycle; stay IDLE.
REQ-020 PAYLOAD: each cycle (T+1..T+4 after header cycle T) SHALL store sio_niu_data into slot beat_cnt and increment beat_cnt.
REQ-021 Beat 3 stored: SHALL complete response (has_data=1), return to IDLE; header may arrive the very next cycle.
REQ-022 Parity: bit i SHALL equal even parity of sio_niu_data[16i+15:16i]; any mismatch in any beat sets accumulated par_err.
REQ-023 Completion SHALL write buffer at the completing edge; rsp_vld SHALL assert the following cycle (latency 1 from beat 3 or header-only cycle).
REQ-024 Buffer SHALL be FIFO, show-ahead; rsp_* stable while rsp_vld & !rsp_rdy.
REQ-025 Full and completion with simultaneous dequeue SHALL accept write; full without dequeue SHALL drop response and set ovf_err.
REQ-026 Empty: rsp_vld=0; rsp_rdy ignored.
REQ-027 niu_sio_credit SHALL pulse the cycle after each dequeue; back-to-back dequeues give back-to-back pulses.
REQ-028 hdr_vld in PAYLOAD: SHALL discard partial response, set proto_err, process new header per REQ-018/019.
REQ-029 Pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.

Reset
REQ-030 rst SHALL force: FSM IDLE, beat_cnt 0, FIFO empty, rsp_vld 0, niu_sio_credit 0, proto_err 0, ovf_err 0; rsp_hdr/rsp_data/rsp_has_data/rsp_par_err 0.
REQ-031 rst mid-payload SHALL discard the partial response; no credit pulse issued.
REQ-032 Inputs SHALL be ignored in any cycle rst=1.

Configuration
REQ-033 Macro NIU_SIO_PAR_CHK_EN defined: parity checked per REQ-022.
REQ-034 Undefined: no parity logic, sio_niu_parity unused, rsp_par_err tied 0.

Structure
REQ-035 Package niu_sio_pkg SHALL hold FSM state typedef, HDR_W=128, BEAT_W=128, BEATS=4, PAR_W=8, response struct {hdr, data, has_data, par_err}.
REQ-036 Buffer SHALL be sub-module niu_sio_rsp_fifo (parameter DEPTH, show-ahead, full/empty).

Verification
REQ-037 Header 0x..A5 with datareq=1, beats 0x1,0x2,0x3,0x4, correct parity -> rsp_vld 1 cycle after beat 3, rsp_data[511:384]=0x4, has_data=1, par_err=0.
REQ-038 Header-only (datareq=0) with rsp_rdy=1 -> rsp_vld next cycle, has_data=0, rsp_data=0; niu_sio_credit pulse cycle after accept.
REQ-039 Beat 2 parity bit 0 flipped (NIU_SIO_PAR_CHK_EN) -> rsp_par_err=1; without macro -> 0.
REQ-040 rsp_rdy=0, three header-only responses, DEPTH=2 -> two buffered, third dropped, ovf_err=1, no credit pulses.
REQ-041 Header at beat 1 of a payload -> proto_err=1, first response never appears, second header delivered normally.
REQ-042 rst at beat 2 -> rsp_vld stays 0, next full transfer delivered correctly.
